// File: rtl/vec_store_unit_if.sv
// Bundle of command, register-file read and memory-write signals for vec_store_unit.
// slave = the store unit itself, master = the surrounding decoder/register-file/memory side.
interface vec_store_unit_if #(
  parameter int DATA_W = 512,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_reg;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wr_data;
  logic              mem_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_reg, cmd_addr, rf_rd_data, mem_ready,
    output cmd_ready, rf_rd_addr, mem_wr_en, mem_addr, mem_wr_data, busy, done
  );

  modport master (
    output cmd_valid, cmd_reg, cmd_addr, rf_rd_data, mem_ready,
    input  cmd_ready, rf_rd_addr, mem_wr_en, mem_addr, mem_wr_data, busy, done
  );
endinterface

// File: rtl/vec_store_unit.sv
// Streams one vector register to memory as NBEATS word writes, lowest word first,
// from a snapshot taken during the READ cycle; one beat retires per mem_ready cycle.
module vec_store_unit #(
  parameter int DATA_W = 512,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  vec_store_unit_if.slave  bus
);
  localparam int NBEATS = DATA_W / WORD_W;
  localparam int BEAT_W = $clog2(NBEATS);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        rf_rd_addr_q, rf_rd_addr_d;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BEAT_W-1:0] beat_inc;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic              done_q, done_d;

  logic [WORD_W-1:0] snap_words [NBEATS];

  generate
    for (genvar gi = 0; gi < NBEATS; gi++) begin : g_words
      assign snap_words[gi] = snap_q[gi*WORD_W +: WORD_W];
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    rf_rd_addr_d  = rf_rd_addr_q;
    snap_d        = snap_q;
    beat_d        = beat_q;
    mem_wr_en_d   = mem_wr_en_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    done_d        = 1'b0;
    beat_inc      = beat_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        mem_wr_en_d = 1'b0;
        if (bus.cmd_valid) begin
          rf_rd_addr_d = bus.cmd_reg;
          // mem_addr doubles as the running address register, starting at base
          mem_addr_d   = bus.cmd_addr;
          state_d      = S_READ;
        end
      end
      S_READ: begin
        // Beat 0 comes straight from the read port so it is on the bus in the first SEND cycle
        snap_d        = bus.rf_rd_data;
        beat_d        = '0;
        mem_wr_data_d = bus.rf_rd_data[WORD_W-1:0];
        mem_wr_en_d   = 1'b1;
        state_d       = S_SEND;
      end
      S_SEND: begin
        if (bus.mem_ready) begin
          mem_addr_d = mem_addr_q + 1'b1;
          if (beat_q == BEAT_W'(NBEATS - 1)) begin
            mem_wr_en_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end else begin
            beat_d        = beat_inc;
            mem_wr_data_d = snap_words[beat_inc];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rf_rd_addr_q  <= '0;
      snap_q        <= '0;
      beat_q        <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rf_rd_addr_q  <= rf_rd_addr_d;
      snap_q        <= snap_d;
      beat_q        <= beat_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      done_q        <= done_d;
    end
  end

  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.rf_rd_addr  = rf_rd_addr_q;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.done        = done_q;
endmodule
